// File: rtl/logo_pkg.sv
// Shared types and default screen/sprite geometry for the bouncing logo demo.
// The geometry defaults are also used by the pixel renderer.
package logo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int LOGO_H_VISIBLE = 640;
  localparam int LOGO_V_VISIBLE = 480;
  localparam int LOGO_OBJ_W     = 85;
  localparam int LOGO_OBJ_H     = 50;
  localparam int LOGO_PAD       = 50;

endpackage

// File: rtl/axis_bounce.sv
// Single-axis step-and-bounce: next position, next direction and wall-hit flag.
// Purely combinational; the sum is formed one bit wider than the position.
module axis_bounce (
  input  logic [9:0] pos_i,
  input  logic       dir_i,
  input  logic [2:0] step_i,
  input  logic [9:0] min_i,
  input  logic [9:0] max_i,
  output logic [9:0] next_pos_o,
  output logic       next_dir_o,
  output logic       hit_o
);

  logic [10:0] fwd;
  logic [10:0] low_lim;

  assign fwd     = {1'b0, pos_i} + {8'd0, step_i};
  assign low_lim = {1'b0, min_i} + {8'd0, step_i};

  always_comb begin
    next_pos_o = pos_i;
    next_dir_o = dir_i;
    hit_o      = 1'b0;
    if (dir_i) begin
      if (fwd >= {1'b0, max_i}) begin
        next_pos_o = max_i;
        next_dir_o = 1'b0;
        hit_o      = 1'b1;
      end else begin
        next_pos_o = fwd[9:0];
      end
    end else begin
      // Clamping at min+step keeps the subtraction from ever underflowing.
      if ({1'b0, pos_i} <= low_lim) begin
        next_pos_o = min_i;
        next_dir_o = 1'b1;
        hit_o      = 1'b1;
      end else begin
        next_pos_o = pos_i - {7'd0, step_i};
      end
    end
  end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Per-frame logo motion scheduler: tick -> CALC -> COMMIT, outputs change two edges after the tick.
// Ticks arriving mid-update are dropped; defining LOGO_CORNER_CNT_EN enables the corner_hits counter.
module logo_motion_ctrl
  import logo_pkg::*;
#(
  parameter int H_VISIBLE    = LOGO_H_VISIBLE,
  parameter int V_VISIBLE    = LOGO_V_VISIBLE,
  parameter int OBJ_W        = LOGO_OBJ_W,
  parameter int OBJ_H        = LOGO_OBJ_H,
  parameter int PAD          = LOGO_PAD,
  parameter int X_START      = 50,
  parameter int Y_START      = 50,
  parameter int MOVE_EVERY   = 2,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       dir_right,
  output logic       dir_down,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic       bg_flash,
  output logic       update_done,
  output logic [9:0] frame_count,
  output logic [7:0] corner_hits
);

  localparam logic [9:0] XMIN = 10'(PAD);
  localparam logic [9:0] XMAX = 10'(H_VISIBLE - PAD - OBJ_W);
  localparam logic [9:0] YMIN = 10'(PAD);
  localparam logic [9:0] YMAX = 10'(V_VISIBLE - PAD - OBJ_H);
  localparam int DIV_W = (MOVE_EVERY > 1) ? $clog2(MOVE_EVERY) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_EVERY - 1);
  localparam int FL_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLASH_FRAMES);

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d, fc_q, fc_d;
  logic             dr_q, dr_d, dd_q, dd_d, ndr_q, ndr_d, ndd_q, ndd_d;
  logic             hx_q, hx_d, hy_q, hy_d, move_q, move_d;
  logic             bx_q, bx_d, by_q, by_d, upd_q, upd_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [FL_W-1:0]  flash_q, flash_d;
  logic [2:0]       step;
  logic [9:0]       ax_pos, ay_pos;
  logic             ax_dir, ay_dir, ax_hit, ay_hit;

  assign step = {1'b0, speed} + 3'd1;

  axis_bounce u_axis_x (
    .pos_i(x_q), .dir_i(dr_q), .step_i(step), .min_i(XMIN), .max_i(XMAX),
    .next_pos_o(ax_pos), .next_dir_o(ax_dir), .hit_o(ax_hit)
  );

  axis_bounce u_axis_y (
    .pos_i(y_q), .dir_i(dd_q), .step_i(step), .min_i(YMIN), .max_i(YMAX),
    .next_pos_o(ay_pos), .next_dir_o(ay_dir), .hit_o(ay_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    div_d   = div_q;
    move_d  = move_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    ndr_d   = ndr_q;
    ndd_d   = ndd_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    x_d     = x_q;
    y_d     = y_q;
    dr_d    = dr_q;
    dd_d    = dd_q;
    flash_d = flash_q;
    bx_d    = 1'b0;
    by_d    = 1'b0;
    upd_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_CALC;
          fc_d    = fc_q + 10'd1;
          div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          move_d  = (div_q == DIV_LAST) && !pause;
        end
      end
      ST_CALC: begin
        state_d = ST_COMMIT;
        // Results are staged here so the visible position only changes at COMMIT.
        nx_d  = move_q ? ax_pos : x_q;
        ny_d  = move_q ? ay_pos : y_q;
        ndr_d = move_q ? ax_dir : dr_q;
        ndd_d = move_q ? ay_dir : dd_q;
        hx_d  = move_q && ax_hit;
        hy_d  = move_q && ay_hit;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        x_d     = nx_q;
        y_d     = ny_q;
        dr_d    = ndr_q;
        dd_d    = ndd_q;
        bx_d    = hx_q;
        by_d    = hy_q;
        upd_d   = 1'b1;
        if (hx_q || hy_q)       flash_d = FL_LOAD;
        else if (flash_q != '0) flash_d = flash_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= 10'(X_START);
      y_q     <= 10'(Y_START);
      dr_q    <= 1'b1;
      dd_q    <= 1'b1;
      nx_q    <= '0;
      ny_q    <= '0;
      ndr_q   <= 1'b1;
      ndd_q   <= 1'b1;
      hx_q    <= 1'b0;
      hy_q    <= 1'b0;
      move_q  <= 1'b0;
      fc_q    <= '0;
      div_q   <= '0;
      flash_q <= '0;
      bx_q    <= 1'b0;
      by_q    <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dr_q    <= dr_d;
      dd_q    <= dd_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      ndr_q   <= ndr_d;
      ndd_q   <= ndd_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      move_q  <= move_d;
      fc_q    <= fc_d;
      div_q   <= div_d;
      flash_q <= flash_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      upd_q   <= upd_d;
    end
  end

`ifdef LOGO_CORNER_CNT_EN
  logic [7:0] corner_q, corner_d;

  always_comb begin
    corner_d = corner_q;
    if (state_q == ST_COMMIT && hx_q && hy_q && corner_q != 8'hFF)
      corner_d = corner_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) corner_q <= '0;
    else        corner_q <= corner_d;
  end

  assign corner_hits = corner_q;
`else
  assign corner_hits = '0;
`endif

  assign obj_x       = x_q;
  assign obj_y       = y_q;
  assign dir_right   = dr_q;
  assign dir_down    = dd_q;
  assign bounce_x    = bx_q;
  assign bounce_y    = by_q;
  assign update_done = upd_q;
  assign bg_flash    = (flash_q != '0);
  assign frame_count = fc_q;

endmodule
